// File: rtl/battery_display.sv
// battery_display: subtract-10 decimal conversion of the battery level, two-digit
// scanned 7-segment drive, low/empty blink and charge dot. LOW_BEEP_EN adds a buzzer.
module battery_display #(
   parameter int unsigned SCAN_DIV   = 50000,
   parameter int unsigned LOW_THRESH = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] battery,
   input  logic       battery_empty,
   input  logic       sw0,
   input  logic       timer_500ms,
   input  logic       timer_250ms,
   output logic [7:0] seg,
   output logic [1:0] an,
   output logic       beep
);

   localparam int unsigned      CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [7:0]       THRESH   = 8'(LOW_THRESH);
   localparam logic [6:0]       DASH     = 7'h40;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    glyph = 7'h3F;
         4'd1:    glyph = 7'h06;
         4'd2:    glyph = 7'h5B;
         4'd3:    glyph = 7'h4F;
         4'd4:    glyph = 7'h66;
         4'd5:    glyph = 7'h6D;
         4'd6:    glyph = 7'h7D;
         4'd7:    glyph = 7'h07;
         4'd8:    glyph = 7'h7F;
         4'd9:    glyph = 7'h6F;
         default: glyph = 7'h00;
      endcase
   endfunction

   typedef enum logic {CONV_IDLE, CONV_RUN} conv_state_t;

   conv_state_t conv_state, conv_next;
   logic [7:0]  level_q, level_d;
   logic [6:0]  rem, rem_d;
   logic [3:0]  tens_acc, tens_acc_d;
   logic [3:0]  tens_r, tens_r_d;
   logic [3:0]  ones_r, ones_r_d;
   logic        busy;

   assign busy = (conv_state == CONV_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conv_state <= CONV_IDLE;
         level_q    <= 8'hFF;
         rem        <= '0;
         tens_acc   <= '0;
         tens_r     <= '0;
         ones_r     <= '0;
      end else begin
         conv_state <= conv_next;
         level_q    <= level_d;
         rem        <= rem_d;
         tens_acc   <= tens_acc_d;
         tens_r     <= tens_r_d;
         ones_r     <= ones_r_d;
      end
   end

   // Both digits are committed together in the final cycle, so the pair is never torn.
   always_comb begin
      conv_next  = conv_state;
      level_d    = level_q;
      rem_d      = rem;
      tens_acc_d = tens_acc;
      tens_r_d   = tens_r;
      ones_r_d   = ones_r;
      if (!busy) begin
         if (battery != level_q) begin
            level_d    = battery;
            rem_d      = (battery > 8'd99) ? 7'd99 : battery[6:0];
            tens_acc_d = '0;
            conv_next  = CONV_RUN;
         end
      end else if (rem >= 7'd10) begin
         rem_d      = rem - 7'd10;
         tens_acc_d = tens_acc + 4'd1;
      end else begin
         tens_r_d  = tens_acc;
         ones_r_d  = rem[3:0];
         conv_next = CONV_IDLE;
      end
   end

   logic [CNT_W-1:0] scan_cnt;
   logic             digit_sel;
   logic             blink_on;
   logic             blink_cond;

   assign blink_cond = (battery_empty || (level_q < THRESH)) && !sw0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt  <= '0;
         digit_sel <= 1'b0;
         blink_on  <= 1'b1;
      end else begin
         if (scan_cnt == CNT_LAST) begin
            scan_cnt  <= '0;
            digit_sel <= ~digit_sel;
         end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
         end
         if (!blink_cond)
            blink_on <= 1'b1;
         else if (timer_500ms)
            blink_on <= ~blink_on;
      end
   end

   logic [7:0] seg_d;
   logic [1:0] an_d;

   always_comb begin
      seg_d = '0;
      an_d  = '0;
      if (blink_on) begin
         if (!digit_sel) begin
            an_d       = 2'b01;
            seg_d[6:0] = battery_empty ? DASH : glyph(ones_r);
            seg_d[7]   = sw0;
         end else begin
            an_d = 2'b10;
            if (battery_empty)
               seg_d[6:0] = DASH;
            else if (tens_r != 4'd0)
               seg_d[6:0] = glyph(tens_r);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= '0;
         an  <= '0;
      end else begin
         seg <= seg_d;
         an  <= an_d;
      end
   end

`ifdef LOW_BEEP_EN
   typedef enum logic {BEEP_IDLE, BEEP_RUN} beep_state_t;

   beep_state_t beep_state, beep_next;
   logic [2:0]  tick_cnt, tick_cnt_d;
   logic        beep_q, beep_d;
   logic        sw0_q;
   logic        cross;

   // Crossing is judged at capture time: the old level_q against the incoming level.
   assign cross = !busy && (battery != level_q) && (level_q >= THRESH) &&
                  (battery < THRESH) && !sw0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beep_state <= BEEP_IDLE;
         tick_cnt   <= '0;
         beep_q     <= 1'b0;
         sw0_q      <= 1'b0;
      end else begin
         beep_state <= beep_next;
         tick_cnt   <= tick_cnt_d;
         beep_q     <= beep_d;
         sw0_q      <= sw0;
      end
   end

   always_comb begin
      beep_next  = beep_state;
      tick_cnt_d = tick_cnt;
      beep_d     = beep_q;
      if (sw0 && !sw0_q) begin
         beep_next  = BEEP_IDLE;
         tick_cnt_d = '0;
         beep_d     = 1'b0;
      end else if (cross) begin
         beep_next  = BEEP_RUN;
         tick_cnt_d = '0;
         beep_d     = 1'b0;
      end else if ((beep_state == BEEP_RUN) && timer_250ms) begin
         if (tick_cnt == 3'd5) begin
            beep_next  = BEEP_IDLE;
            tick_cnt_d = '0;
            beep_d     = 1'b0;
         end else begin
            tick_cnt_d = tick_cnt + 3'd1;
            beep_d     = ~beep_q;
         end
      end
   end

   assign beep = beep_q;
`else
   logic unused_timer_250ms;
   assign unused_timer_250ms = timer_250ms;
   assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_battery_display.sv
// Self-checking bench for battery_display: directed blink/empty/charge/latency steps
// followed by randomized levels, checked against an arithmetic display model.
module tb_battery_display;

   localparam int unsigned D  = 4;
   localparam int unsigned LT = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] battery = 8'd99;
   logic       battery_empty = 1'b0;
   logic       sw0 = 1'b0;
   logic       timer_500ms = 1'b0;
   logic       timer_250ms = 1'b0;
   logic [7:0] seg;
   logic [1:0] an;
   logic       beep;

   int          checks = 0;
   int          errors = 0;
   int unsigned edge_n = 0;
   logic        exp_blink = 1'b1;
   logic [6:0]  glyphs [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   battery_display #(.SCAN_DIV(D), .LOW_THRESH(LT)) dut (
      .clk(clk), .rst_n(rst_n), .battery(battery), .battery_empty(battery_empty),
      .sw0(sw0), .timer_500ms(timer_500ms), .timer_250ms(timer_250ms),
      .seg(seg), .an(an), .beep(beep)
   );

   always #5 clk = ~clk;

   // Edges since reset release; selects which scan slot the outputs should show.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_n <= 0;
      else        edge_n <= edge_n + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] model_out(input int lvl, input logic emp, input logic chg,
                                            input int slot, input logic blk);
      int         v;
      int         t;
      int         o;
      logic [7:0] s;
      logic [1:0] a;
      v = (lvl > 99) ? 99 : lvl;
      t = v / 10;
      o = v % 10;
      s = '0;
      a = '0;
      if (blk) begin
         if (slot == 0) begin
            a      = 2'b01;
            s[6:0] = emp ? 7'h40 : glyphs[o];
            s[7]   = chg;
         end else begin
            a      = 2'b10;
            s[6:0] = emp ? 7'h40 : ((t == 0) ? 7'h00 : glyphs[t]);
         end
      end
      return {s, a};
   endfunction

   task automatic check_display(input string tag, input int lvl);
      logic [9:0] e;
      int         slot;
      for (int i = 0; i < 2 * D; i++) begin
         @(negedge clk);
         slot = int'(((edge_n - 1) / D) % 2);
         e = model_out(lvl, battery_empty, sw0, slot, exp_blink);
         chk({tag, "_seg"}, 32'(seg), 32'(e[9:2]));
         chk({tag, "_an"}, 32'(an), 32'(e[1:0]));
`ifndef LOW_BEEP_EN
         chk({tag, "_beep"}, 32'(beep), 32'd0);
`endif
      end
   endtask

   function automatic logic blink_cond(input int lvl);
      return (battery_empty || (lvl < LT)) && !sw0;
   endfunction

   task automatic settle(input int lvl);
      repeat (14) @(negedge clk);
      if (!blink_cond(lvl)) exp_blink = 1'b1;
   endtask

   task automatic pulse500(input int lvl);
      @(negedge clk);
      timer_500ms = 1'b1;
      @(negedge clk);
      timer_500ms = 1'b0;
      if (blink_cond(lvl)) exp_blink = ~exp_blink;
   endtask

   task automatic pulse250();
      @(negedge clk);
      timer_250ms = 1'b1;
      @(negedge clk);
      timer_250ms = 1'b0;
   endtask

   initial begin
      int   lvl;
      int   v;
      logic ok;
      logic [7:0] prev;
      logic [7:0] pair;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_seg", 32'(seg), 32'd0);
      chk("rst_an", 32'(an), 32'd0);
      chk("rst_beep", 32'(beep), 32'd0);
      chk("rst_level", 32'(dut.level_q), 32'hFF);
      chk("rst_busy", 32'(dut.busy), 32'd0);
      chk("rst_blink", 32'(dut.blink_on), 32'd1);

      // First capture right after release; 99 commits at edge 2 + 9
      rst_n = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         chk($sformatf("lat_tens_%0d", n), 32'(dut.tens_r), (n >= 11) ? 32'd9 : 32'd0);
         chk($sformatf("lat_ones_%0d", n), 32'(dut.ones_r), (n >= 11) ? 32'd9 : 32'd0);
      end
      check_display("d99", 99);

      // Single digit, low level: blanked tens, blink 0,1,0
      lvl = 7; battery = 8'd7; settle(lvl);
      check_display("d7", lvl);
      for (int k = 0; k < 3; k++) begin
         pulse500(lvl);
         chk($sformatf("blink7_%0d", k), 32'(dut.blink_on), 32'(exp_blink));
         check_display($sformatf("d7_b%0d", k), lvl);
      end

      // Over-range clamps to 99; empty shows dashes and blinks
      lvl = 150; battery = 8'd150; settle(lvl);
      check_display("d150", lvl);
      battery_empty = 1'b1; settle(lvl);
      check_display("empty", lvl);
      for (int k = 0; k < 2; k++) begin
         pulse500(lvl);
         check_display($sformatf("empty_b%0d", k), lvl);
      end

      // Charging: no blink, dot on ones slot only
      battery_empty = 1'b0; sw0 = 1'b1; lvl = 5; battery = 8'd5; settle(lvl);
      check_display("chg5", lvl);
      for (int k = 0; k < 2; k++) begin
         pulse500(lvl);
         chk($sformatf("chg_blink_%0d", k), 32'(dut.blink_on), 32'd1);
         check_display($sformatf("chg5_p%0d", k), lvl);
      end

      // Change while busy: only whole committed pairs may ever appear
      prev = {dut.tens_r, dut.ones_r};
      battery = 8'd40;
      @(negedge clk);
      battery = 8'd39;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         pair = {dut.tens_r, dut.ones_r};
         ok = (pair == prev) || (pair == 8'h40) || (pair == 8'h39);
         chk($sformatf("atomic_%0d", n), 32'(ok), 32'd1);
      end
      chk("final39", 32'({dut.tens_r, dut.ones_r}), 32'h39);
      check_display("d39", 39);

      // Reset during a conversion commits nothing
      battery = 8'd88;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_tens", 32'(dut.tens_r), 32'd0);
      chk("mid_rst_ones", 32'(dut.ones_r), 32'd0);
      chk("mid_rst_busy", 32'(dut.busy), 32'd0);
      chk("mid_rst_seg", 32'(seg), 32'd0);
      chk("mid_rst_an", 32'(an), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_blink = 1'b1;
      settle(88);
      chk("post_rst_pair", 32'({dut.tens_r, dut.ones_r}), 32'h88);
      check_display("d88", 88);

      // Randomized levels, charge and empty; no blink ticks so blink_on stays 1
      for (int r = 0; r < 24; r++) begin
         lvl = int'($urandom_range(0, 255));
         battery = 8'(lvl);
         sw0 = 1'($urandom_range(0, 1));
         battery_empty = 1'($urandom_range(0, 1));
         settle(lvl);
         v = (lvl > 99) ? 99 : lvl;
         chk($sformatf("rnd%0d_tens", r), 32'(dut.tens_r), 32'(v / 10));
         chk($sformatf("rnd%0d_ones", r), 32'(dut.ones_r), 32'(v % 10));
         check_display($sformatf("rnd%0d", r), lvl);
      end

`ifdef LOW_BEEP_EN
      sw0 = 1'b0; battery_empty = 1'b0;
      battery = 8'd20; settle(20);
      battery = 8'd19; settle(19);
      chk("beep_armed", 32'(beep), 32'd0);
      for (int k = 1; k <= 7; k++) begin
         pulse250();
         chk($sformatf("beep_t%0d", k), 32'(beep), (k <= 6) ? 32'(k % 2) : 32'd0);
      end
      sw0 = 1'b1;
      battery = 8'd20; settle(20);
      battery = 8'd19; settle(19);
      for (int k = 1; k <= 3; k++) begin
         pulse250();
         chk($sformatf("beep_chg%0d", k), 32'(beep), 32'd0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
